// File: rtl/climate_sequencer_if.sv
// Request/actuator bundle between the front-panel mode controller and the climate sequencer.
// The master drives the mode requests and the slave drives the actuators and status.
interface climate_sequencer_if;
    logic       en_i;
    logic [2:0] velMode_i;
    logic [2:0] tempMode_i;
    logic       fan_pwm_o;
    logic       heat_pwm_o;
    logic [2:0] fan_lvl_o;
    logic [1:0] state_o;
    logic       busy_o;

    modport master (
        output en_i, velMode_i, tempMode_i,
        input  fan_pwm_o, heat_pwm_o, fan_lvl_o, state_o, busy_o
    );

    modport slave (
        input  en_i, velMode_i, tempMode_i,
        output fan_pwm_o, heat_pwm_o, fan_lvl_o, state_o, busy_o
    );
endinterface

// File: rtl/climate_sequencer.sv
// Fan/heater sequencer: ramped fan level, glitch-free PWM, a heater interlock on fan speed,
// and a forced fan cool-down period after the heater stops.
module climate_sequencer #(
    parameter int LEVEL_STEP  = 20,
    parameter int RAMP_CYC    = 5000,
    parameter int COOL_CYC    = 50000,
    parameter int MIN_FAN_LVL = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    climate_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PREFAN = 2'd1, HEAT = 2'd2, COOL = 2'd3} state_t;

    localparam int PERIOD = 5 * LEVEL_STEP;
    localparam int DUTY_W = $clog2(PERIOD + 1);
    localparam int RAMP_W = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
    localparam int COOL_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;

    localparam logic [2:0]        MIN_LVL   = 3'(MIN_FAN_LVL);
    localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(LEVEL_STEP);
    localparam logic [DUTY_W-1:0] PWM_LAST  = DUTY_W'(PERIOD - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYC - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOL_CYC - 1);

    function automatic logic [2:0] clamp5(input logic [2:0] x);
        return (x > 3'd5) ? 3'd5 : x;
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          fan_lvl_q, fan_lvl_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [COOL_W-1:0]   cool_cnt_q, cool_cnt_d;
    logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0]   fan_duty_q, fan_duty_d;
    logic [DUTY_W-1:0]   heat_duty_q, heat_duty_d;
    logic                fan_pwm_q, fan_pwm_d;
    logic                heat_pwm_q, heat_pwm_d;
    logic [2:0]          v, t, fan_tgt;
    logic                period_end;

    always_comb begin
        v       = bus.en_i ? clamp5(bus.velMode_i)  : 3'd0;
        t       = bus.en_i ? clamp5(bus.tempMode_i) : 3'd0;
        fan_tgt = (state_q == IDLE || v >= MIN_LVL) ? v : MIN_LVL;

        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        case (state_q)
            IDLE:    if (t != 3'd0) state_d = PREFAN;
            PREFAN:  if (t == 3'd0) state_d = IDLE;
                     else if (fan_lvl_q >= MIN_LVL) state_d = HEAT;
            HEAT:    if (t == 3'd0) begin
                         state_d    = COOL;
                         cool_cnt_d = COOL_LOAD;
                     end
            COOL:    if (t != 3'd0) state_d = HEAT;
                     else if (cool_cnt_q == '0) state_d = IDLE;
                     else cool_cnt_d = cool_cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase

        // Fan only ever moves one level per ramp period, in either direction.
        ramp_cnt_d = (ramp_cnt_q == RAMP_LAST) ? '0 : ramp_cnt_q + 1'b1;
        fan_lvl_d  = fan_lvl_q;
        if (ramp_cnt_q == RAMP_LAST) begin
            if (fan_lvl_q < fan_tgt)      fan_lvl_d = fan_lvl_q + 3'd1;
            else if (fan_lvl_q > fan_tgt) fan_lvl_d = fan_lvl_q - 3'd1;
        end

        period_end  = (pwm_cnt_q == PWM_LAST);
        pwm_cnt_d   = period_end ? '0 : pwm_cnt_q + 1'b1;
        fan_duty_d  = period_end ? DUTY_W'(fan_lvl_q) * STEP : fan_duty_q;
        heat_duty_d = period_end ? DUTY_W'(t) * STEP : heat_duty_q;

        // Heater gating looks at the next state so leaving HEAT kills the output at once.
        fan_pwm_d  = (pwm_cnt_q < fan_duty_q);
        heat_pwm_d = (state_d == HEAT) && (fan_lvl_d >= MIN_LVL) && (pwm_cnt_q < heat_duty_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fan_lvl_q   <= '0;
            ramp_cnt_q  <= '0;
            cool_cnt_q  <= '0;
            pwm_cnt_q   <= '0;
            fan_duty_q  <= '0;
            heat_duty_q <= '0;
            fan_pwm_q   <= 1'b0;
            heat_pwm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fan_lvl_q   <= fan_lvl_d;
            ramp_cnt_q  <= ramp_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            fan_duty_q  <= fan_duty_d;
            heat_duty_q <= heat_duty_d;
            fan_pwm_q   <= fan_pwm_d;
            heat_pwm_q  <= heat_pwm_d;
        end
    end

    assign bus.fan_pwm_o  = fan_pwm_q;
    assign bus.heat_pwm_o = heat_pwm_q;
    assign bus.fan_lvl_o  = fan_lvl_q;
    assign bus.state_o    = state_q;
    assign bus.busy_o     = (fan_lvl_q != fan_tgt) || (state_q == PREFAN) || (state_q == COOL);
endmodule

// File: tb/tb_climate_sequencer.sv
// Directed bench for climate_sequencer: fan-level scoreboard, PWM duty windows, interlock,
// cool-down timing, reheat, clamping/enable and asynchronous reset.
module tb_climate_sequencer;
    logic clk;
    logic rst;
    climate_sequencer_if bus();

    climate_sequencer #(
        .LEVEL_STEP(4), .RAMP_CYC(8), .COOL_CYC(40), .MIN_FAN_LVL(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;
    logic [2:0] exp_q[$];
    logic [2:0] last_lvl;

    // Heater must never be on while the fan is below the minimum level.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.heat_pwm_o === 1'b1 && bus.fan_lvl_o < 3'd2) viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pop the next expected fan level once the DUT's level changes; report cycles waited.
    task automatic sb_next(input string tag, output int cyc);
        logic [2:0] expv;
        cyc = 0;
        while (bus.fan_lvl_o === last_lvl && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd7;
        check(tag, 32'(bus.fan_lvl_o), 32'(expv));
        last_lvl = bus.fan_lvl_o;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int c = 0;
        while (bus.state_o !== s && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(bus.state_o), 32'(s));
    endtask

    // Wait for the heater output to rise at a period start.
    task automatic sync_heat_rise(input string tag);
        int c = 0;
        while (bus.heat_pwm_o !== 1'b0 && c < 40) begin @(negedge clk); c++; end
        while (bus.heat_pwm_o !== 1'b1 && c < 80) begin @(negedge clk); c++; end
        check(tag, 32'(bus.heat_pwm_o), 32'd1);
    endtask

    task automatic count_high(input int n, output int fh, output int hh);
        fh = 0;
        hh = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.fan_pwm_o === 1'b1)  fh++;
            if (bus.heat_pwm_o === 1'b1) hh++;
        end
    endtask

    initial begin
        int cyc;
        int fh;
        int hh;
        int cool_len;

        rst = 1'b1;
        bus.en_i = 1'b0;
        bus.velMode_i = 3'd0;
        bus.tempMode_i = 3'd0;
        last_lvl = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_fan_pwm",  32'(bus.fan_pwm_o),  32'd0);
        check("rst_heat_pwm", 32'(bus.heat_pwm_o), 32'd0);
        check("rst_fan_lvl",  32'(bus.fan_lvl_o),  32'd0);
        check("rst_state",    32'(bus.state_o),    32'd0);
        check("rst_busy",     32'(bus.busy_o),     32'd0);

        // 1: fan ramp to 3
        rst = 1'b0;
        bus.en_i = 1'b1;
        bus.velMode_i = 3'd3;
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
        sb_next("ramp_up_l1", cyc);
        check("busy_ramping", 32'(bus.busy_o), 32'd1);
        sb_next("ramp_up_l2", cyc);
        check("ramp_int_l2", 32'(cyc), 32'd8);
        sb_next("ramp_up_l3", cyc);
        check("ramp_int_l3", 32'(cyc), 32'd8);
        check("busy_settled", 32'(bus.busy_o), 32'd0);
        repeat (40) @(negedge clk);
        count_high(20, fh, hh);
        $display("t1 fan ramp: fan_high=%0d heat_high=%0d", fh, hh);
        check("fan_duty_l3", 32'(fh), 32'd12);
        check("heat_off_idle", 32'(hh), 32'd0);

        // 2: interlock from fan level 0
        bus.velMode_i = 3'd0;
        exp_q.push_back(3'd2); exp_q.push_back(3'd1); exp_q.push_back(3'd0);
        sb_next("ramp_dn_l2", cyc);
        sb_next("ramp_dn_l1", cyc);
        check("ramp_int_dn", 32'(cyc), 32'd8);
        sb_next("ramp_dn_l0", cyc);
        bus.tempMode_i = 3'd4;
        @(negedge clk);
        check("prefan_state", 32'(bus.state_o), 32'd1);
        check("prefan_busy",  32'(bus.busy_o),  32'd1);
        check("prefan_heat",  32'(bus.heat_pwm_o), 32'd0);
        exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        sb_next("prefan_l1", cyc);
        check("prefan_heat_l1", 32'(bus.heat_pwm_o), 32'd0);
        sb_next("prefan_l2", cyc);
        check("prefan_hold", 32'(bus.state_o), 32'd1);
        @(negedge clk);
        check("heat_entered", 32'(bus.state_o), 32'd2);
        repeat (40) @(negedge clk);
        count_high(20, fh, hh);
        $display("t2 interlock: fan_high=%0d heat_high=%0d", fh, hh);
        check("heat_duty_t4", 32'(hh), 32'd16);
        check("fan_duty_min", 32'(fh), 32'd8);

        // 3: cool-down
        sync_heat_rise("heat_sync_t3");
        bus.tempMode_i = 3'd0;
        @(negedge clk);
        check("heat_kill_t3", 32'(bus.heat_pwm_o), 32'd0);
        check("cool_entered", 32'(bus.state_o),    32'd3);
        check("cool_busy",    32'(bus.busy_o),     32'd1);
        cool_len = 0;
        while (bus.state_o === 2'd3 && cool_len < 100) begin
            cool_len++;
            @(negedge clk);
        end
        $display("t3 cool-down: cool_len=%0d", cool_len);
        check("cool_len", 32'(cool_len), 32'd40);
        check("cool_to_idle", 32'(bus.state_o), 32'd0);
        check("cool_fan_held", 32'(bus.fan_lvl_o), 32'd2);
        exp_q.push_back(3'd1); exp_q.push_back(3'd0);
        sb_next("post_cool_l1", cyc);
        sb_next("post_cool_l0", cyc);

        // 4: reheat directly from COOL
        bus.tempMode_i = 3'd2;
        wait_state(2'd2, 60, "reheat_first_heat");
        last_lvl = bus.fan_lvl_o;
        bus.tempMode_i = 3'd0;
        @(negedge clk);
        check("reheat_cool", 32'(bus.state_o), 32'd3);
        repeat (9) @(negedge clk);
        bus.tempMode_i = 3'd2;
        @(negedge clk);
        check("reheat_direct", 32'(bus.state_o), 32'd2);
        repeat (40) @(negedge clk);
        count_high(20, fh, hh);
        $display("t4 reheat: fan_high=%0d heat_high=%0d", fh, hh);
        check("heat_duty_t2", 32'(hh), 32'd8);

        // 5: clamp to level 5, then drop enable
        bus.velMode_i = 3'd7;
        exp_q.push_back(3'd3); exp_q.push_back(3'd4); exp_q.push_back(3'd5);
        sb_next("clamp_l3", cyc);
        sb_next("clamp_l4", cyc);
        check("ramp_int_clamp", 32'(cyc), 32'd8);
        sb_next("clamp_l5", cyc);
        repeat (40) @(negedge clk);
        count_high(20, fh, hh);
        $display("t5 clamp: fan_high=%0d fan_lvl=%0d", fh, bus.fan_lvl_o);
        check("fan_duty_full", 32'(fh), 32'd20);
        check("clamp_hold", 32'(bus.fan_lvl_o), 32'd5);
        sync_heat_rise("heat_sync_t5");
        bus.en_i = 1'b0;
        @(negedge clk);
        check("en_off_heat", 32'(bus.heat_pwm_o), 32'd0);
        check("en_off_cool", 32'(bus.state_o),    32'd3);

        // 6: async reset mid-ramp and mid-period
        repeat (10) @(negedge clk);
        check("pre_rst_lvl_nz", 32'(bus.fan_lvl_o != 3'd0), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        $display("t6 async reset: fan_pwm=%0d state=%0d fan_lvl=%0d", bus.fan_pwm_o, bus.state_o, bus.fan_lvl_o);
        check("arst_fan_pwm",  32'(bus.fan_pwm_o),  32'd0);
        check("arst_heat_pwm", 32'(bus.heat_pwm_o), 32'd0);
        check("arst_fan_lvl",  32'(bus.fan_lvl_o),  32'd0);
        check("arst_state",    32'(bus.state_o),    32'd0);
        check("arst_busy",     32'(bus.busy_o),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_lvl",   32'(bus.fan_lvl_o), 32'd0);
        check("post_rst_state", 32'(bus.state_o),   32'd0);

        check("interlock_viol", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
